// File: rtl/mux41_pkg.sv
// Shared types and constants for the mux41 round-robin arbiter slice.
package mux41_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first requester after ptr, wrapping 0..3.
module rr_pick4
  import mux41_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   idx,
  output logic               valid
);

  logic [SEL_W-1:0] cand;

  // The ptr slot itself is visited last (k == NUM_REQ wraps back to ptr).
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ptr + SEL_W'(k);
      if (!valid && req[cand]) begin
        valid     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/mux41_rr_arbiter.sv
// Round-robin arbiter driving the mux41 select lines with a bounded hold time.
// Optional owner lock input enabled by defining MUX41_ARB_LOCK_EN.
module mux41_rr_arbiter
  import mux41_pkg::*;
#(
  parameter int HOLD_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
`ifdef MUX41_ARB_LOCK_EN
  input  logic               lock,
`endif
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               s1,
  output logic               s0,
  output logic               busy
);

  localparam int HOLD_W = $clog2(HOLD_MAX + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               busy_q, busy_d;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [SEL_W-1:0]   pick_idx;
  logic               pick_valid;
  logic               owner_req;
  logic               lock_hold;

`ifdef MUX41_ARB_LOCK_EN
  assign lock_hold = lock;
`else
  assign lock_hold = 1'b0;
`endif

  // Masking out the current owner turns the picker into "someone else pending";
  // in IDLE gnt_q is zero so the same instance serves the initial grant.
  rr_pick4 u_pick (
    .req   (req & ~gnt_q),
    .ptr   (ptr_q),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign owner_req = |(req & gnt_q);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          gnt_d   = pick_gnt;
          sel_d   = pick_idx;
          ptr_d   = pick_idx;
          hold_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!owner_req) begin
          hold_d = '0;
          if (pick_valid) begin
            gnt_d = pick_gnt;
            sel_d = pick_idx;
            ptr_d = pick_idx;
          end else begin
            gnt_d   = '0;
            state_d = IDLE;
          end
        end else if (lock_hold) begin
          hold_d = hold_q;
        end else if (hold_q == HOLD_LAST) begin
          hold_d = '0;
          if (pick_valid) begin
            gnt_d = pick_gnt;
            sel_d = pick_idx;
            ptr_d = pick_idx;
          end
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        hold_d  = '0;
      end
    endcase
    busy_d = |gnt_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= SEL_W'(NUM_REQ - 1);
      hold_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt  = gnt_q;
  assign s1   = sel_q[1];
  assign s0   = sel_q[0];
  assign busy = busy_q;

endmodule

// File: tb/tb_mux41_rr_arbiter.sv
// Scoreboard bench for mux41_rr_arbiter (HOLD_MAX=4); lock test under MUX41_ARB_LOCK_EN.
module tb_mux41_rr_arbiter;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    string      tag;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       lock;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       s1;
  logic       s0;
  logic       busy;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  mux41_rr_arbiter #(.HOLD_MAX(4)) dut (
    .clk  (clk),
    .rst  (rst),
`ifdef MUX41_ARB_LOCK_EN
    .lock (lock),
`endif
    .req  (req),
    .gnt  (gnt),
    .s1   (s1),
    .s0   (s0),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic applyStimulus(input logic r, input logic [3:0] rq, input logic lk,
                               input logic [3:0] eg, input logic [1:0] es, input string tag);
    exp_t e;
    @(negedge clk);
    rst  = r;
    req  = rq;
    lock = lk;
    e.gnt  = eg;
    e.sel  = es;
    e.busy = (eg != 4'b0000);
    e.tag  = tag;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    checks++;
    if (gnt !== e.gnt) begin
      failures++;
      $display("[TB] FAIL %s gnt: got %b want %b (req=%b lock=%0b) t=%0t", e.tag, gnt, e.gnt, req, lock, $time);
    end
    checks++;
    if ({s1, s0} !== e.sel) begin
      failures++;
      $display("[TB] FAIL %s sel: got %b want %b t=%0t", e.tag, {s1, s0}, e.sel, $time);
    end
    checks++;
    if (busy !== e.busy) begin
      failures++;
      $display("[TB] FAIL %s busy: got %b want %b t=%0t", e.tag, busy, e.busy, $time);
    end
    checks++;
    if ($countones(gnt) > 1) begin
      failures++;
      $display("[TB] FAIL %s onehot: got %b want at most one bit set", e.tag, gnt);
    end
  endtask

  // Monitor: the arbiter presents a registered output every cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    logic [3:0] rot_gnt [4];
    logic [1:0] rot_sel [4];
    rot_gnt = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rot_sel = '{2'b01, 2'b10, 2'b11, 2'b00};
    rst  = 1'b1;
    req  = 4'b0000;
    lock = 1'b0;

    // Reset held two cycles with all requesters active
    applyStimulus(1, 4'b1111, 0, 4'b0000, 2'b00, "reset0");
    applyStimulus(1, 4'b1111, 0, 4'b0000, 2'b00, "reset1");

    // Rotation: each owner holds exactly four cycles
    for (int i = 0; i < 4; i++) applyStimulus(0, 4'b1111, 0, 4'b0001, 2'b00, "rot_first");
    for (int o = 0; o < 4; o++)
      for (int i = 0; i < 4; i++) applyStimulus(0, 4'b1111, 0, rot_gnt[o], rot_sel[o], "rot");

    // Voluntary release with direct handoff, then drop to idle
    applyStimulus(1, 4'b0000, 0, 4'b0000, 2'b00, "vr_reset");
    applyStimulus(0, 4'b0100, 0, 4'b0100, 2'b10, "vr_grant2");
    applyStimulus(0, 4'b0101, 0, 4'b0100, 2'b10, "vr_hold2");
    applyStimulus(0, 4'b0001, 0, 4'b0001, 2'b00, "vr_handoff0");
    applyStimulus(0, 4'b0000, 0, 4'b0000, 2'b00, "vr_idle");
    applyStimulus(0, 4'b1000, 0, 4'b1000, 2'b11, "vr_grant3");
    applyStimulus(0, 4'b0000, 0, 4'b0000, 2'b11, "idle_sel_keep");
    applyStimulus(0, 4'b0000, 0, 4'b0000, 2'b11, "idle_sel_keep2");

    // Sole requester keeps the grant through counter reloads
    for (int i = 0; i < 20; i++) applyStimulus(0, 4'b1000, 0, 4'b1000, 2'b11, "sole3");
    // Counter sits at HOLD_MAX-1 here, so a new requester forces a handoff at once
    applyStimulus(0, 4'b1001, 0, 4'b0001, 2'b00, "limit_handoff");

    // Mid-grant reset restores ptr=3, so requester 1 wins over 2
    applyStimulus(0, 4'b0010, 0, 4'b0010, 2'b01, "mr_to1");
    applyStimulus(0, 4'b0110, 0, 4'b0010, 2'b01, "mr_hold1");
    applyStimulus(1, 4'b0110, 0, 4'b0000, 2'b00, "mr_reset");
    applyStimulus(0, 4'b0110, 0, 4'b0010, 2'b01, "mr_regrant1");
    applyStimulus(0, 4'b0110, 0, 4'b0010, 2'b01, "mr_hold1b");
    applyStimulus(0, 4'b0000, 0, 4'b0000, 2'b01, "mr_idle");

`ifdef MUX41_ARB_LOCK_EN
    // Bring owner 0 to the hold limit, lock it there, then release the lock
    applyStimulus(1, 4'b0000, 0, 4'b0000, 2'b00, "lk_reset");
    for (int i = 0; i < 4; i++) applyStimulus(0, 4'b0011, 0, 4'b0001, 2'b00, "lk_pre");
    for (int i = 0; i < 10; i++) applyStimulus(0, 4'b0011, 1, 4'b0001, 2'b00, "lk_locked");
    applyStimulus(0, 4'b0011, 0, 4'b0010, 2'b01, "lk_release");
`endif

    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux41_rr_arbiter.md
Name: mux41_rr_arbiter

Overview:
Round-robin arbiter that shares the 4:1 mux (mux41) output path between four requesters in the visitor-counter datapath. It grants one requester at a time, drives mux select lines s1/s0 to match the owner, and enforces a maximum hold time so that no requester can starve the others. It sits between the sensor/event sources and the mux41 instance.

Parameters:
HOLD_MAX, 4, maximum consecutive cycles one requester may hold the grant while others are waiting (legal range 1..255).

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
req  input  4  request vector; req[i] high = requester i wants mux path
gnt  output 4  one-hot grant vector; all-zero when idle
s1   output 1  mux select MSB; {s1,s0} = index of current owner
s0   output 1  mux select LSB
busy output 1  high while any grant is active

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst); both are fixed.
- On reset: gnt=4'b0000, {s1,s0}=2'b00, busy=0, state=IDLE, rr pointer=3 so requester 0 has highest priority first, hold counter=0.
- States: IDLE, GRANT.
- Grant latency: 1 cycle. A request sampled on edge N produces gnt on edge N+1.
- Search order: starting at (ptr+1) mod 4 and wrapping 0→1→2→3→0. ptr holds the index of the last granted requester.
- IDLE:
  - req==0: stay in IDLE.
  - Otherwise grant the first requester in search order, load ptr, clear hold counter, go to GRANT.
- GRANT, owner o, each cycle, in this priority:
  - req[o]=0 (voluntary release): if another requester is pending, hand off directly to it with no idle cycle; otherwise gnt=0 and go to IDLE.
  - req[o]=1, hold counter == HOLD_MAX-1, and another requester pending: forced handoff to the next requester in search order.
  - req[o]=1, hold counter == HOLD_MAX-1, and no other requester pending: owner keeps the grant and the counter reloads to 0.
  - Otherwise hold the grant and increment the counter.
- Hold counter width: $clog2(HOLD_MAX+1). It saturates logically and never wraps past HOLD_MAX-1.
- {s1,s0} updates on the same edge as gnt. In IDLE it retains the last owner index, to avoid mux glitching.
- busy = |gnt, registered.
- gnt is always one-hot or zero. Two bits set at once is illegal.
- Simultaneous requests: resolved purely by search order. No requester is granted twice in a row while another is pending at the hold limit.
- rst asserted mid-grant: the next edge forces the reset values regardless of req.

Optional Feature:
MUX41_ARB_LOCK_EN.
- Defined: adds input port lock (1 bit). While lock=1 and the owner's req=1, the hold-limit handoff is suppressed and the counter is held. Voluntary release still works. lock is ignored in IDLE.
- Undefined: no lock port. Hold limit is always enforced.

Decomposition:
- Shared package mux41_pkg holds:
  - state typedef (IDLE, GRANT)
  - constant NUM_REQ=4
  - SEL_W=2
- Natural sub-module: rr_pick4. It is combinational: given req and ptr it returns the one-hot next grant and its index. It is reused for both IDLE grants and handoffs.

Test Plan:
- Reset: hold rst=1 for 2 cycles with req=4'b1111 → gnt=0000, {s1,s0}=00, busy=0. Release rst → next cycle gnt=0001, {s1,s0}=00.
- Rotation: req=4'b1111 constant, HOLD_MAX=4 → each grant lasts 4 cycles, in order 0001→0010→0100→1000→0001, with s1s0 tracking 00→01→10→11→00.
- Voluntary release: grant 2, drop req[2] after 1 cycle with req[0]=1 → next cycle gnt=0001 with no idle cycle. Then drop req[0] with no others pending → gnt=0000, busy=0, s1s0 stays 00.
- Sole requester: only req[3]=1 for 20 cycles → gnt=1000 continuously, counter reloads, no gaps.
- Mid-grant reset: req=0110 while gnt=0010, assert rst one cycle → gnt=0000. After release, grant goes to requester 1 (ptr reset to 3).
- Lock (MUX41_ARB_LOCK_EN defined): req=0011, owner 0, lock=1 for 10 cycles → gnt stays 0001. Lower lock → handoff to 0010 within 1 cycle.
